// File: rtl/lpc_pkg.sv
// Shared LPC target definitions: FSM states, cycle types, SYNC codes.
// Imported by the I/O-cycle front end.
package lpc_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CYCTYPE,
    ADDR,
    WDATA,
    HTAR,
    SYNC,
    RDATA,
    PTAR,
    IGNORE
  } lpc_state_t;

  localparam logic [2:0] CYC_IO_RD = 3'b000;
  localparam logic [2:0] CYC_IO_WR = 3'b001;

  localparam logic [3:0] SYNC_READY = 4'h0;
  localparam logic [3:0] SYNC_LWAIT = 4'h6;
  localparam logic [3:0] SYNC_ERR   = 4'hA;

  localparam int LPC_WIN_BITS = 5;

endpackage

// File: rtl/lpc_io_cycle_slave.sv
// LPC I/O-cycle target: decodes host I/O cycles into a 32-byte window,
// strobes the register bank and returns SYNC plus read data on LAD.
module lpc_io_cycle_slave #(
  parameter logic [15:0] BASE_ADDR  = 16'h0800,
  parameter logic [3:0]  SYNC_READY = 4'h0
) (
  input  logic       LpcClock,
  input  logic       PciReset,
  input  logic       LFRAME_N,
  input  logic [3:0] LAD_in,
  output logic [3:0] LAD_out,
  output logic       LAD_oe,
  output logic [7:0] Addr,
  output logic       Wr,
  output logic       Rd,
  output logic [7:0] DataWrSW,
  input  logic [7:0] RdData
);

  import lpc_pkg::*;

  lpc_state_t  state;
  lpc_state_t  nxt;
  logic [1:0]  cnt;
  logic        is_wr;
  logic [11:0] addr_sh;
  logic [3:0]  data_lo;
  logic [7:0]  rd_data;
  logic [15:0] io_addr;
  logic        hit;
  logic        io_cyc;

  assign io_addr = {addr_sh, LAD_in};
  assign hit = io_addr[15:LPC_WIN_BITS]
            == BASE_ADDR[15:LPC_WIN_BITS];
  assign io_cyc = (LAD_in[3:1] == CYC_IO_RD)
               || (LAD_in[3:1] == CYC_IO_WR);

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = IDLE;
      CYCTYPE: nxt = io_cyc ? ADDR : IGNORE;
      ADDR: begin
        if (cnt == 2'd3) begin
          if (!hit)       nxt = IGNORE;
          else if (is_wr) nxt = WDATA;
          else            nxt = HTAR;
        end
      end
      WDATA:   if (cnt == 2'd1) nxt = HTAR;
      HTAR:    if (cnt == 2'd1) nxt = SYNC;
      SYNC:    nxt = is_wr ? PTAR : RDATA;
      RDATA:   if (cnt == 2'd1) nxt = PTAR;
      PTAR:    if (cnt == 2'd1) nxt = IDLE;
      IGNORE:  nxt = IGNORE;
      default: nxt = IDLE;
    endcase
    // host framing wins over everything
    if (!LFRAME_N)
      nxt = (LAD_in == 4'h0) ? CYCTYPE : IDLE;
  end

  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      state    <= IDLE;
      cnt      <= '0;
      is_wr    <= 1'b0;
      addr_sh  <= '0;
      data_lo  <= '0;
      rd_data  <= '0;
      Addr     <= '0;
      DataWrSW <= '0;
    end else begin
      state <= nxt;
      cnt   <= (nxt != state) ? 2'd0 : cnt + 2'd1;
      if (state == CYCTYPE)
        is_wr <= (LAD_in[3:1] == CYC_IO_WR);
      if (state == ADDR)
        addr_sh <= io_addr[11:0];
      if (state == ADDR && (nxt == WDATA || nxt == HTAR))
        Addr <= {{(8-LPC_WIN_BITS){1'b0}},
                 io_addr[LPC_WIN_BITS-1:0]};
      if (state == WDATA && cnt == 2'd0)
        data_lo <= LAD_in;
      if (state == WDATA && nxt == HTAR)
        DataWrSW <= {LAD_in, data_lo};
      if (state == SYNC && nxt == RDATA)
        rd_data <= RdData;
    end
  end

  // LAD and strobes come from registered state only
  always_comb begin
    LAD_oe  = 1'b0;
    LAD_out = 4'hF;
    Wr      = 1'b0;
    Rd      = 1'b0;
    unique case (1'b1)
      (state == SYNC): begin
        LAD_oe  = 1'b1;
        LAD_out = SYNC_READY;
        Wr      = is_wr;
        Rd      = !is_wr;
      end
      (state == RDATA): begin
        LAD_oe  = 1'b1;
        LAD_out = cnt[0] ? rd_data[7:4] : rd_data[3:0];
      end
      (state == PTAR): LAD_oe = (cnt == 2'd0);
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lpc_io_cycle_slave.sv
// Bench for lpc_io_cycle_slave: per-cycle vector tables built from
// transaction-level timelines, directed corners and random traffic.
module tb_lpc_io_cycle_slave;

  localparam logic [15:0] BASE = 16'h0800;

  logic       LpcClock;
  logic       PciReset;
  logic       LFRAME_N;
  logic [3:0] LAD_in;
  logic [3:0] LAD_out;
  logic       LAD_oe;
  logic [7:0] Addr;
  logic       Wr;
  logic       Rd;
  logic [7:0] DataWrSW;
  logic [7:0] RdData;

  lpc_io_cycle_slave #(
    .BASE_ADDR (BASE),
    .SYNC_READY(4'h0)
  ) dut (
    .LpcClock(LpcClock),
    .PciReset(PciReset),
    .LFRAME_N(LFRAME_N),
    .LAD_in  (LAD_in),
    .LAD_out (LAD_out),
    .LAD_oe  (LAD_oe),
    .Addr    (Addr),
    .Wr      (Wr),
    .Rd      (Rd),
    .DataWrSW(DataWrSW),
    .RdData  (RdData)
  );

  initial LpcClock = 1'b0;
  always #15 LpcClock = ~LpcClock;

  typedef struct {
    logic       lf;
    logic [3:0] lad;
    logic [7:0] rdd;
    logic       oe;
    logic [3:0] out;
    logic       wr;
    logic       rd;
    logic [7:0] addr;
    logic [7:0] dwr;
  } vec_t;

  vec_t q[$];
  vec_t carry;
  logic [7:0] m_addr;
  logic [7:0] m_dwr;
  int n_vec;
  int n_err;

  task automatic set_idle_carry();
    carry.lf  = 1'b1;
    carry.lad = 4'hF;
    carry.rdd = 8'h00;
    carry.oe  = 1'b0;
    carry.out = 4'hF;
    carry.wr  = 1'b0;
    carry.rd  = 1'b0;
    carry.addr = m_addr;
    carry.dwr  = m_dwr;
  endtask

  // kind 0 = I/O write, 1 = I/O read, 2 = non-I/O cycle type.
  // len < 13 truncates: the next pushed record must be a new START.
  task automatic push_cycle(input int kind, input logic [15:0] a,
                            input logic [7:0] d, input int len);
    vec_t r[14];
    logic hit;
    logic [7:0] na;
    hit = (a[15:5] == BASE[15:5]) && (kind != 2);
    na  = {3'b000, a[4:0]};
    for (int k = 0; k < 14; k++) begin
      r[k].lf   = 1'b1;
      r[k].lad  = 4'($urandom);
      r[k].rdd  = 8'($urandom);
      r[k].oe   = 1'b0;
      r[k].out  = 4'hF;
      r[k].wr   = 1'b0;
      r[k].rd   = 1'b0;
      r[k].addr = (hit && k >= 6) ? na : m_addr;
      r[k].dwr  = (hit && kind == 0 && k >= 8) ? d : m_dwr;
    end
    r[0].lf  = 1'b0;
    r[0].lad = 4'h0;
    r[0].oe  = carry.oe;
    r[0].out = carry.out;
    r[0].wr  = carry.wr;
    r[0].rd  = carry.rd;
    if (kind == 0)      r[1].lad = {3'b001, 1'($urandom)};
    else if (kind == 1) r[1].lad = {3'b000, 1'($urandom)};
    else                r[1].lad = 4'(4 + $urandom_range(0, 11));
    r[2].lad = a[15:12];
    r[3].lad = a[11:8];
    r[4].lad = a[7:4];
    r[5].lad = a[3:0];
    if (kind == 0) begin
      r[6].lad = d[3:0];
      r[7].lad = d[7:4];
    end
    if (hit && kind == 0) begin
      r[10].oe = 1'b1; r[10].out = 4'h0; r[10].wr = 1'b1;
      r[11].oe = 1'b1; r[11].out = 4'hF;
    end
    if (hit && kind == 1) begin
      r[8].oe  = 1'b1; r[8].out  = 4'h0; r[8].rd = 1'b1;
      r[8].rdd = d;
      r[9].oe  = 1'b1; r[9].out  = d[3:0];
      r[10].oe = 1'b1; r[10].out = d[7:4];
      r[11].oe = 1'b1; r[11].out = 4'hF;
    end
    for (int k = 0; k < len; k++) q.push_back(r[k]);
    carry  = r[len];
    m_addr = r[len].addr;
    m_dwr  = r[len].dwr;
  endtask

  task automatic push_idle(input int n);
    vec_t v;
    for (int k = 0; k < n; k++) begin
      v = carry;
      v.lf  = 1'b1;
      v.lad = 4'($urandom);
      v.rdd = 8'($urandom);
      q.push_back(v);
    end
  endtask

  task automatic push_abort_idle();
    vec_t v;
    v = carry;
    v.lf  = 1'b0;
    v.lad = 4'(1 + $urandom_range(0, 14));
    v.rdd = 8'($urandom);
    q.push_back(v);
    set_idle_carry();
  endtask

  task automatic run_q(input string tag);
    foreach (q[i]) begin
      LFRAME_N = q[i].lf;
      LAD_in   = q[i].lad;
      RdData   = q[i].rdd;
      #1;
      n_vec++;
      if (LAD_oe !== q[i].oe || (q[i].oe && LAD_out !== q[i].out)
          || Wr !== q[i].wr || Rd !== q[i].rd
          || Addr !== q[i].addr || DataWrSW !== q[i].dwr) begin
        n_err++;
        $display("FAIL %s[%0d]: got oe=%b lad=%h wr=%b rd=%b addr=%h dwr=%h, want oe=%b lad=%h wr=%b rd=%b addr=%h dwr=%h",
                 tag, i, LAD_oe, LAD_out, Wr, Rd, Addr, DataWrSW,
                 q[i].oe, q[i].out, q[i].wr, q[i].rd,
                 q[i].addr, q[i].dwr);
      end
      @(posedge LpcClock);
      #1;
    end
    q.delete();
  endtask

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, want);
    end
  endtask

  initial begin
    int kind;
    int len;
    logic [15:0] a;
    n_vec    = 0;
    n_err    = 0;
    m_addr   = 8'h00;
    m_dwr    = 8'h00;
    PciReset = 1'b0;
    LFRAME_N = 1'b1;
    LAD_in   = 4'hF;
    RdData   = 8'h00;
    set_idle_carry();
    #1;
    chk("reset_oe", {15'd0, LAD_oe}, 16'd0);
    chk("reset_lad", {12'd0, LAD_out}, 16'h000F);
    chk("reset_strobes", {14'd0, Wr, Rd}, 16'd0);
    chk("reset_addr_dwr", {Addr, DataWrSW}, 16'h0000);
    @(posedge LpcClock);
    @(posedge LpcClock);
    #1;
    PciReset = 1'b1;
    @(posedge LpcClock);
    #1;

    push_idle(2);
    push_cycle(0, 16'h0805, 8'h3C, 13);
    push_idle(2);
    push_cycle(1, 16'h080B, 8'h5A, 13);
    run_q("basic");

    push_cycle(1, 16'h0810, 8'hE1, 13);
    push_cycle(0, 16'h081F, 8'hA5, 13);
    run_q("b2b");

    push_cycle(1, 16'h0900, 8'h77, 13);
    push_idle(1);
    push_cycle(2, 16'h0805, 8'h00, 13);
    push_idle(1);
    run_q("ignore");

    push_cycle(0, 16'h0803, 8'h77, 7);
    push_cycle(0, 16'h0804, 8'h11, 13);
    run_q("abort_wr");

    push_cycle(1, 16'h0816, 8'h9C, 10);
    push_abort_idle();
    push_idle(1);
    push_cycle(0, 16'h0800, 8'h42, 13);
    run_q("abort_rd");

    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 2);
      if ($urandom_range(0, 3) != 0)
        a = BASE + 16'($urandom_range(0, 31));
      else begin
        a = 16'($urandom);
        if (a[15:5] == BASE[15:5]) a[15] = 1'b1;
      end
      len = ($urandom_range(0, 2) == 0) ? $urandom_range(2, 12) : 13;
      push_cycle(kind, a, 8'($urandom), len);
      if (len < 13) begin
        if ($urandom_range(0, 1) == 1) push_abort_idle();
      end else begin
        push_idle($urandom_range(0, 2));
      end
    end
    push_idle(1);
    run_q("random");

    push_cycle(1, 16'h0812, 8'hC3, 8);
    run_q("pre_reset");
    chk("sync_before_reset", {14'd0, LAD_oe, Rd}, 16'h0003);
    #5;
    PciReset = 1'b0;
    #1;
    chk("async_reset_oe_rd", {14'd0, LAD_oe, Rd}, 16'h0000);
    chk("async_reset_regs", {Addr, DataWrSW}, 16'h0000);
    @(posedge LpcClock);
    @(posedge LpcClock);
    #1;
    LFRAME_N = 1'b1;
    PciReset = 1'b1;
    m_addr = 8'h00;
    m_dwr  = 8'h00;
    set_idle_carry();
    @(posedge LpcClock);
    #1;
    push_idle(2);
    push_cycle(0, 16'h0807, 8'h96, 13);
    push_idle(1);
    run_q("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
